// File: rtl/window_kxk_if.sv
// Pixel-column input and KxK window output bundle for window_kxk.
// The source drives through master; the window generator sits on slave.
interface window_kxk_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int K          = 3
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                      in_valid;
  logic                      in_sof;
  logic [K*DATA_WIDTH-1:0]   rows_in;
  logic                      win_valid;
  logic [K*K*DATA_WIDTH-1:0] win;
  logic [XW-1:0]             win_x;
  logic [YW-1:0]             win_y;
  logic                      win_eof;

  modport master (
    output in_valid, in_sof, rows_in,
    input  win_valid, win, win_x, win_y, win_eof
  );

  modport slave (
    input  in_valid, in_sof, rows_in,
    output win_valid, win, win_x, win_y, win_eof
  );
endinterface

// File: rtl/window_kxk.sv
// KxK sliding-window generator: K line taps per column enter K-deep column shift
// registers; a registered window leaves one cycle after each window-complete column.
module window_kxk #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int K          = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  window_kxk_if.slave  bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int WW = K*K*DATA_WIDTH;

  logic [WW-1:0] sr_r;
  logic [WW-1:0] nxt_win_s;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [XW-1:0] cur_x_s;
  logic [YW-1:0] cur_y_s;
  logic [XW-1:0] nxt_x_s;
  logic [YW-1:0] nxt_y_s;
  logic          complete_s;
  logic          last_s;
  logic          emit_s;

  logic          win_valid_r;
  logic          win_eof_r;
  logic [WW-1:0] win_r;
  logic [XW-1:0] win_x_r;
  logic [YW-1:0] win_y_r;

  // Coordinates of the column on the bus and the counters that follow it
  always_comb begin
    if (bus.in_sof) begin
      cur_x_s = '0;
      cur_y_s = '0;
    end else begin
      cur_x_s = x_r;
      cur_y_s = y_r;
    end
    if (cur_x_s == XW'(WIDTH-1)) begin
      nxt_x_s = '0;
      if (cur_y_s == YW'(HEIGHT-1)) begin
        nxt_y_s = '0;
      end else begin
        nxt_y_s = cur_y_s + YW'(1);
      end
    end else begin
      nxt_x_s = cur_x_s + XW'(1);
      nxt_y_s = cur_y_s;
    end
    complete_s = (cur_x_s >= XW'(K-1)) && (cur_y_s >= YW'(K-1));
    last_s     = (cur_x_s == XW'(WIDTH-1)) && (cur_y_s == YW'(HEIGHT-1));
    emit_s     = bus.in_valid && complete_s;
  end

  // Window after this column is shifted in: slice k lands in row K-1-k, column K-1
  always_comb begin
    nxt_win_s = sr_r;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) begin
        nxt_win_s[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = sr_r[(r*K+c+1)*DATA_WIDTH +: DATA_WIDTH];
      end
      nxt_win_s[(r*K+K-1)*DATA_WIDTH +: DATA_WIDTH] = bus.rows_in[(K-1-r)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Shift registers and column/line counters advance only on accepted columns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= '0;
      x_r  <= '0;
      y_r  <= '0;
    end else if (bus.in_valid) begin
      sr_r <= nxt_win_s;
      x_r  <= nxt_x_s;
      y_r  <= nxt_y_s;
    end
  end

  // Output stage: window data and coordinates hold between valid windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_r <= 1'b0;
      win_eof_r   <= 1'b0;
      win_r       <= '0;
      win_x_r     <= '0;
      win_y_r     <= '0;
    end else begin
      win_valid_r <= emit_s;
      win_eof_r   <= emit_s && last_s;
      if (emit_s) begin
        win_r   <= nxt_win_s;
        win_x_r <= cur_x_s - XW'(K-1);
        win_y_r <= cur_y_s - YW'(K-1);
      end
    end
  end

  assign bus.win_valid = win_valid_r;
  assign bus.win_eof   = win_eof_r;
  assign bus.win       = win_r;
  assign bus.win_x     = win_x_r;
  assign bus.win_y     = win_y_r;

endmodule

// File: tb/tb_window_kxk.sv
// Self-checking bench for window_kxk (K=3, 8x6 frame) against an image-based
// reference model: each window is read straight out of the frame image by coordinates.
module tb_window_kxk;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  window_kxk_if #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .K(K)) bus ();

  window_kxk #(.DATA_WIDTH(DW), .WIDTH(W), .HEIGHT(H), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: frame image plus next-column coordinates
  logic [DW-1:0]     img [H][W];
  int                mx, my;
  logic              e_valid, e_eof;
  logic [K*K*DW-1:0] e_win;
  logic [2:0]        e_x, e_y;
  int                nwin, neof;

  task automatic fill_img(input bit rnd);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = rnd ? DW'($urandom) : DW'(16*y + x);
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    e_valid = 1'b0; e_eof = 1'b0;
    e_win = '0; e_x = 3'd0; e_y = 3'd0;
  endtask

  // Drive one cycle, predict the registered result, then sample 1 time unit after the edge
  task automatic step(input bit v, input bit s);
    int cx, cy;
    logic [K*DW-1:0] rows;
    for (int k = 0; k < K; k++) rows[k*DW +: DW] = DW'($urandom);
    e_valid = 1'b0;
    e_eof   = 1'b0;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      cx = mx; cy = my;
      for (int k = 0; k < K; k++)
        if (cy - k >= 0) rows[k*DW +: DW] = img[cy-k][cx];
      if (cx >= K-1 && cy >= K-1) begin
        e_valid = 1'b1;
        e_eof   = (cx == W-1) && (cy == H-1);
        e_x     = 3'(cx - (K-1));
        e_y     = 3'(cy - (K-1));
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            e_win[(r*K+c)*DW +: DW] = img[cy-(K-1)+r][cx-(K-1)+c];
      end
      mx = mx + 1;
      if (mx == W) begin
        mx = 0; my = my + 1;
        if (my == H) my = 0;
      end
    end
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.rows_in  = rows;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_sof = 1'b0; bus.rows_in = '1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({bus.win_valid, bus.win_eof, bus.win, bus.win_x, bus.win_y} !== '0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need all zero",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_continuous_frame();
    bit first;
    fill_img(1'b0);
    nwin = 0; neof = 0; first = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, i == 0);
      vectors++;
      if (bus.win_valid !== e_valid || bus.win_eof !== e_eof || bus.win !== e_win ||
          bus.win_x !== e_x || bus.win_y !== e_y) begin
        miscompares++;
        $display("FAIL cont_frame col=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need v=%b e=%b x=%0d y=%0d win=%h",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win,
                 e_valid, e_eof, e_x, e_y, e_win);
      end
      if (bus.win_valid === 1'b1 && first) begin
        first = 1'b0;
        vectors++;
        if (bus.win !== 72'h22_21_20_12_11_10_02_01_00 || bus.win_x !== 3'd0 || bus.win_y !== 3'd0) begin
          miscompares++;
          $display("FAIL first_window: got x=%0d y=%0d win=%h, need x=0 y=0 win=222120121110020100",
                   bus.win_x, bus.win_y, bus.win);
        end
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.win_eof === 1'b1) neof++;
    end
    vectors++;
    if (nwin != 24 || neof != 1) begin
      miscompares++;
      $display("FAIL cont_count: got windows=%0d eofs=%0d, need 24 and 1", nwin, neof);
    end
  endtask

  task automatic test_toggle_valid();
    fill_img(1'b1);
    nwin = 0; neof = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      step(i[0] == 1'b0, i == 0);
      vectors++;
      if (bus.win_valid !== e_valid || bus.win_eof !== e_eof || bus.win !== e_win ||
          bus.win_x !== e_x || bus.win_y !== e_y) begin
        miscompares++;
        $display("FAIL toggle cyc=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need v=%b e=%b x=%0d y=%0d win=%h",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win,
                 e_valid, e_eof, e_x, e_y, e_win);
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.win_eof === 1'b1) neof++;
    end
    vectors++;
    if (nwin != 24 || neof != 1) begin
      miscompares++;
      $display("FAIL toggle_count: got windows=%0d eofs=%0d, need 24 and 1", nwin, neof);
    end
  endtask

  // Random duty with stray in_sof on idle cycles, which must be ignored
  task automatic test_random_duty();
    int accepted;
    bit v;
    accepted = 0; nwin = 0; neof = 0;
    fill_img(1'b1);
    for (int i = 0; i < 2000 && accepted < 3*W*H; i++) begin
      v = ($urandom_range(0, 99) < 60);
      step(v, v ? (accepted == 0) : 1'($urandom));
      if (v) accepted++;
      vectors++;
      if (bus.win_valid !== e_valid || bus.win_eof !== e_eof || bus.win !== e_win ||
          bus.win_x !== e_x || bus.win_y !== e_y) begin
        miscompares++;
        $display("FAIL random_duty cyc=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need v=%b e=%b x=%0d y=%0d win=%h",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win,
                 e_valid, e_eof, e_x, e_y, e_win);
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.win_eof === 1'b1) neof++;
    end
    vectors++;
    if (accepted != 3*W*H || nwin != 72 || neof != 3) begin
      miscompares++;
      $display("FAIL random_count: got cols=%0d windows=%0d eofs=%0d, need 144, 72 and 3", accepted, nwin, neof);
    end
  endtask

  task automatic test_mid_sof();
    fill_img(1'b0);
    nwin = 0; neof = 0;
    for (int i = 0; i < 3*W + 4 + W*H; i++) begin
      step(1'b1, i == 0 || i == 3*W + 4);
      vectors++;
      if (bus.win_valid !== e_valid || bus.win_eof !== e_eof || bus.win !== e_win ||
          bus.win_x !== e_x || bus.win_y !== e_y) begin
        miscompares++;
        $display("FAIL mid_sof col=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need v=%b e=%b x=%0d y=%0d win=%h",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win,
                 e_valid, e_eof, e_x, e_y, e_win);
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.win_eof === 1'b1) neof++;
    end
    vectors++;
    if (nwin != 32 || neof != 1) begin
      miscompares++;
      $display("FAIL mid_sof_count: got windows=%0d eofs=%0d, need 32 and 1", nwin, neof);
    end
  endtask

  task automatic test_reset_mid();
    fill_img(1'b0);
    for (int i = 0; i < 4*W + 6; i++) step(1'b1, i == 0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.win_valid, bus.win_eof, bus.win, bus.win_x, bus.win_y} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got v=%b e=%b x=%0d y=%0d win=%h, need all zero",
               bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win);
    end
    model_reset();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nwin = 0; neof = 0;
    for (int i = 0; i < W*H; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (bus.win_valid !== e_valid || bus.win_eof !== e_eof || bus.win !== e_win ||
          bus.win_x !== e_x || bus.win_y !== e_y) begin
        miscompares++;
        $display("FAIL after_reset col=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need v=%b e=%b x=%0d y=%0d win=%h",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win,
                 e_valid, e_eof, e_x, e_y, e_win);
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.win_eof === 1'b1) neof++;
    end
    vectors++;
    if (nwin != 24 || neof != 1) begin
      miscompares++;
      $display("FAIL after_reset_count: got windows=%0d eofs=%0d, need 24 and 1", nwin, neof);
    end
  endtask

  task automatic test_back_to_back();
    fill_img(1'b1);
    nwin = 0; neof = 0;
    for (int i = 0; i < 2*W*H; i++) begin
      step(1'b1, i == 0);
      vectors++;
      if (bus.win_valid !== e_valid || bus.win_eof !== e_eof || bus.win !== e_win ||
          bus.win_x !== e_x || bus.win_y !== e_y) begin
        miscompares++;
        $display("FAIL back_to_back col=%0d: got v=%b e=%b x=%0d y=%0d win=%h, need v=%b e=%b x=%0d y=%0d win=%h",
                 i, bus.win_valid, bus.win_eof, bus.win_x, bus.win_y, bus.win,
                 e_valid, e_eof, e_x, e_y, e_win);
      end
      if (bus.win_valid === 1'b1) nwin++;
      if (bus.win_eof === 1'b1) neof++;
    end
    vectors++;
    if (nwin != 48 || neof != 2) begin
      miscompares++;
      $display("FAIL b2b_count: got windows=%0d eofs=%0d, need 48 and 2", nwin, neof);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.rows_in = '0;
    model_reset();
    test_reset();
    test_continuous_frame();
    test_toggle_valid();
    test_random_duty();
    test_mid_sof();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
